// File: rtl/led_bit_encoder.sv
// WS2812 single-wire encoder: serializes 24-bit GRB words MSB first and generates the latch low period.
// Optional sticky inter-pixel gap flag `underrun` is built only when LED_ENC_UNDERRUN_EN is defined.
module led_bit_encoder #(
  parameter int T0H_CYCLES   = 40,
  parameter int T1H_CYCLES   = 80,
  parameter int BIT_CYCLES   = 125,
  parameter int RESET_CYCLES = 5000
) (
  input  logic        clk_100mhz,
  input  logic        sys_rst,
  input  logic [23:0] pixel_data,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  input  logic        latch_req,
  output logic        busy,
  output logic        latch_done,
  output logic        signal_out,
`ifdef LED_ENC_UNDERRUN_EN
  output logic        underrun,
`endif
  output logic [1:0]  dbg_state
);

  // Handshake: a pixel moves on any cycle where pixel_valid && pixel_ready are both high;
  // pixel_ready never depends on pixel_valid, and pixel_data must be stable while pixel_valid is high.

  // The cycle counter must hold RESET_CYCLES in LATCH and BIT_CYCLES-1 in SEND.
  localparam int CW_RST = $clog2(RESET_CYCLES + 1);
  localparam int CW_BIT = $clog2(BIT_CYCLES);
  localparam int CW     = (CW_RST > CW_BIT) ? CW_RST : CW_BIT;

  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES);
  localparam logic [CW-1:0] T0H      = CW'(T0H_CYCLES);
  localparam logic [CW-1:0] T1H      = CW'(T1H_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [23:0]   r_shift;
  logic [23:0]   w_shift_nxt;
  logic [4:0]    r_bit_idx;
  logic [4:0]    w_bit_idx_nxt;
  logic [CW-1:0] r_cyc;
  logic [CW-1:0] w_cyc_nxt;
  logic          r_latch_pending;
  logic          w_latch_pending_nxt;
  logic          r_signal_out;
  logic          w_signal_nxt;

  logic w_bit_end;
  logic w_pix_end;
  logic w_xfer;
  logic w_latch_end;
  logic w_pend;

  assign w_bit_end   = (r_cyc == BIT_LAST);
  assign w_pix_end   = (r_state == S_SEND) && w_bit_end && (r_bit_idx == 5'd0);
  assign pixel_ready = !r_latch_pending && !sys_rst && ((r_state == S_IDLE) || w_pix_end);
  assign w_xfer      = pixel_valid && pixel_ready;
  assign w_latch_end = (r_state == S_LATCH) && (r_cyc == RST_LAST);
  // A request arriving on the last cycle of a pixel counts as already pending.
  assign w_pend      = r_latch_pending || latch_req;

  always_comb begin
    w_state_nxt         = r_state;
    w_shift_nxt         = r_shift;
    w_bit_idx_nxt       = r_bit_idx;
    w_cyc_nxt           = r_cyc;
    w_latch_pending_nxt = r_latch_pending;

    if (latch_req && (r_state != S_LATCH)) begin
      w_latch_pending_nxt = 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          w_state_nxt   = S_SEND;
          w_shift_nxt   = pixel_data;
          w_bit_idx_nxt = 5'd23;
          w_cyc_nxt     = '0;
        end else if (w_pend) begin
          w_state_nxt = S_LATCH;
          w_cyc_nxt   = '0;
        end
      end
      S_SEND: begin
        if (!w_bit_end) begin
          w_cyc_nxt = r_cyc + 1'b1;
        end else if (r_bit_idx != 5'd0) begin
          w_cyc_nxt     = '0;
          w_shift_nxt   = {r_shift[22:0], 1'b0};
          w_bit_idx_nxt = r_bit_idx - 5'd1;
        end else if (w_xfer) begin
          w_shift_nxt   = pixel_data;
          w_bit_idx_nxt = 5'd23;
          w_cyc_nxt     = '0;
        end else begin
          w_cyc_nxt   = '0;
          w_state_nxt = w_pend ? S_LATCH : S_IDLE;
        end
      end
      S_LATCH: begin
        if (w_latch_end) begin
          w_state_nxt         = S_IDLE;
          w_cyc_nxt           = '0;
          w_latch_pending_nxt = 1'b0;
        end else begin
          w_cyc_nxt = r_cyc + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cyc_nxt   = '0;
      end
    endcase

    // Line level is computed from next-cycle state so it lines up with the counter it reflects.
    w_signal_nxt = (w_state_nxt == S_SEND) &&
                   (w_cyc_nxt < (w_shift_nxt[23] ? T1H : T0H));
  end

  always_ff @(posedge clk_100mhz) begin
    if (sys_rst) begin
      r_state         <= S_IDLE;
      r_shift         <= '0;
      r_bit_idx       <= '0;
      r_cyc           <= '0;
      r_latch_pending <= 1'b0;
      r_signal_out    <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_shift         <= w_shift_nxt;
      r_bit_idx       <= w_bit_idx_nxt;
      r_cyc           <= w_cyc_nxt;
      r_latch_pending <= w_latch_pending_nxt;
      r_signal_out    <= w_signal_nxt;
    end
  end

  assign signal_out = r_signal_out;
  assign busy       = (r_state != S_IDLE) || r_latch_pending;
  assign latch_done = w_latch_end;
  assign dbg_state  = r_state;

`ifdef LED_ENC_UNDERRUN_EN
  // A pixel ending with nothing queued behind it and no latch coming is a gap inside the frame.
  logic w_underrun_set;
  logic r_underrun;

  assign w_underrun_set = w_pix_end && !w_xfer && !w_pend;

  always_ff @(posedge clk_100mhz) begin
    if (sys_rst) begin
      r_underrun <= 1'b0;
    end else if (w_latch_end) begin
      r_underrun <= 1'b0;
    end else if (w_underrun_set) begin
      r_underrun <= 1'b1;
    end
  end

  assign underrun = r_underrun;
`endif

endmodule
